// File: rtl/vx_perf_memsys_counters.sv
// Memory-system performance counters: generic event counters plus per-channel read/write/latency
// counters with an indexed one-cycle readout. Define PERF_CTR_SATURATE_EN to clamp counters at all-ones.
module vx_perf_memsys_counters #(
    parameter int NUM_EVENTS   = 8,
    parameter int NUM_CHANNELS = 2,
    parameter int CTR_WIDTH    = 44,
    parameter int INC_WIDTH    = 4,
    parameter int PEND_WIDTH   = 8,
    parameter int ADDR_WIDTH   = $clog2(NUM_EVENTS + 3*NUM_CHANNELS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            clear,
    input  logic [NUM_EVENTS*INC_WIDTH-1:0] evt_inc,
    input  logic [NUM_CHANNELS-1:0]         mem_req_fire,
    input  logic [NUM_CHANNELS-1:0]         mem_req_rw,
    input  logic [NUM_CHANNELS-1:0]         mem_rsp_fire,
    input  logic                            rd_req,
    input  logic [ADDR_WIDTH-1:0]           rd_addr,
    output logic                            rd_valid,
    output logic [CTR_WIDTH-1:0]            rd_data,
    output logic                            rd_err,
    output logic [NUM_CHANNELS-1:0]         pend_ovf,
    output logic [NUM_CHANNELS-1:0]         pend_unf
);

    localparam int NUM_CTRS = NUM_EVENTS + 3*NUM_CHANNELS;

    logic [CTR_WIDTH-1:0]  ctr_q  [NUM_CTRS];
    logic [CTR_WIDTH-1:0]  ctr_d  [NUM_CTRS];
    logic [PEND_WIDTH-1:0] pend_q [NUM_CHANNELS];
    logic [PEND_WIDTH-1:0] pend_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] ovf_d;
    logic [NUM_CHANNELS-1:0] unf_d;
    logic [NUM_CHANNELS-1:0] rd_fire;
    logic [NUM_CHANNELS-1:0] wr_fire;
    logic [CTR_WIDTH-1:0]  rd_mux;
    logic                  rd_hit;

    assign rd_fire = mem_req_fire & ~mem_req_rw;
    assign wr_fire = mem_req_fire &  mem_req_rw;

`ifdef PERF_CTR_SATURATE_EN
    function automatic logic [CTR_WIDTH-1:0] ctr_add(input logic [CTR_WIDTH-1:0] a,
                                                     input logic [CTR_WIDTH-1:0] b);
        logic [CTR_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CTR_WIDTH] ? {CTR_WIDTH{1'b1}} : sum[CTR_WIDTH-1:0];
    endfunction
`else
    function automatic logic [CTR_WIDTH-1:0] ctr_add(input logic [CTR_WIDTH-1:0] a,
                                                     input logic [CTR_WIDTH-1:0] b);
        return a + b;
    endfunction
`endif

    // Outstanding-read trackers run regardless of enable/clear so latency stays coherent.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = pend_ovf;
        unf_d  = pend_unf;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (rd_fire[c] && !mem_rsp_fire[c]) begin
                if (&pend_q[c]) begin
                    ovf_d[c] = 1'b1;
                end else begin
                    pend_d[c] = pend_q[c] + 1'b1;
                end
            end else if (!rd_fire[c] && mem_rsp_fire[c]) begin
                if (pend_q[c] == '0) begin
                    unf_d[c] = 1'b1;
                end else begin
                    pend_d[c] = pend_q[c] - 1'b1;
                end
            end
        end
        if (clear) begin
            ovf_d = '0;
            unf_d = '0;
        end
    end

    always_comb begin
        ctr_d = ctr_q;
        if (enable) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                ctr_d[i] = ctr_add(ctr_q[i], CTR_WIDTH'(evt_inc[i*INC_WIDTH +: INC_WIDTH]));
            end
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                ctr_d[NUM_EVENTS + 3*c]     = ctr_add(ctr_q[NUM_EVENTS + 3*c],     CTR_WIDTH'(rd_fire[c]));
                ctr_d[NUM_EVENTS + 3*c + 1] = ctr_add(ctr_q[NUM_EVENTS + 3*c + 1], CTR_WIDTH'(wr_fire[c]));
                ctr_d[NUM_EVENTS + 3*c + 2] = ctr_add(ctr_q[NUM_EVENTS + 3*c + 2], CTR_WIDTH'(pend_q[c]));
            end
        end
        if (clear) begin
            for (int i = 0; i < NUM_CTRS; i++) begin
                ctr_d[i] = '0;
            end
        end
    end

    // Readout samples the pre-update counter values, so a read alongside clear sees old data.
    always_comb begin
        rd_mux = '0;
        rd_hit = 1'b0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) begin
                rd_mux = ctr_q[i];
                rd_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CTRS; i++) begin
                ctr_q[i] <= '0;
            end
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                pend_q[c] <= '0;
            end
            pend_ovf <= '0;
            pend_unf <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            rd_data  <= '0;
        end else begin
            ctr_q    <= ctr_d;
            pend_q   <= pend_d;
            pend_ovf <= ovf_d;
            pend_unf <= unf_d;
            rd_valid <= rd_req;
            rd_err   <= rd_req & ~rd_hit;
            rd_data  <= (rd_req && rd_hit) ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_vx_perf_memsys_counters.sv
// Self-checking bench for vx_perf_memsys_counters: directed scenarios plus a randomized run
// against an index-map reference model; a narrow 8-bit instance covers wrap/clamp.
module tb_vx_perf_memsys_counters;

    localparam int NE    = 8;
    localparam int NC    = 2;
    localparam int CW    = 44;
    localparam int TOTAL = NE + 3*NC;
    localparam int PMAX  = 255;
    localparam longint unsigned CMAX = (64'd1 << CW) - 1;

    logic        clk = 1'b0;
    logic        reset, enable, clear;
    logic [31:0] evt_inc;
    logic [1:0]  req_fire, req_rw, rsp_fire;
    logic        rd_req;
    logic [3:0]  rd_addr;
    logic        rd_valid, rd_err;
    logic [CW-1:0] rd_data;
    logic [1:0]  pend_ovf, pend_unf;

    logic        n_enable, n_clear, n_rd_req;
    logic [31:0] n_evt_inc;
    logic [1:0]  n_zero;
    logic [3:0]  n_rd_addr;
    logic        n_rd_valid, n_rd_err;
    logic [7:0]  n_rd_data;
    logic [1:0]  n_ovf, n_unf;

    int checks = 0;
    int failures = 0;

    longint unsigned m_ctr [TOTAL];
    int              m_pend [NC];
    logic [1:0]      m_ovf, m_unf;
    logic            exp_valid, exp_err;
    longint unsigned exp_data;

    always #5 clk = ~clk;

    vx_perf_memsys_counters dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .evt_inc(evt_inc),
        .mem_req_fire(req_fire), .mem_req_rw(req_rw), .mem_rsp_fire(rsp_fire),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_err(rd_err), .pend_ovf(pend_ovf), .pend_unf(pend_unf)
    );

    vx_perf_memsys_counters #(.CTR_WIDTH(8)) u_narrow (
        .clk(clk), .reset(reset), .enable(n_enable), .clear(n_clear), .evt_inc(n_evt_inc),
        .mem_req_fire(n_zero), .mem_req_rw(n_zero), .mem_rsp_fire(n_zero),
        .rd_req(n_rd_req), .rd_addr(n_rd_addr), .rd_valid(n_rd_valid), .rd_data(n_rd_data),
        .rd_err(n_rd_err), .pend_ovf(n_ovf), .pend_unf(n_unf)
    );

    function automatic longint unsigned madd(longint unsigned a, longint unsigned b);
`ifdef PERF_CTR_SATURATE_EN
        return (a + b > CMAX) ? CMAX : a + b;
`else
        return (a + b) & CMAX;
`endif
    endfunction

    // Advance the reference model with the currently driven inputs, then one clock.
    task automatic step();
        int a;
        int old_pend;
        bit rd, wr, rsp;
        a = int'(rd_addr);
        if (reset) begin
            exp_valid = 1'b0; exp_err = 1'b0; exp_data = 0;
            foreach (m_ctr[i]) m_ctr[i] = 0;
            foreach (m_pend[c]) m_pend[c] = 0;
            m_ovf = '0; m_unf = '0;
        end else begin
            exp_valid = rd_req;
            exp_err   = rd_req && (a >= TOTAL);
            exp_data  = (rd_req && a < TOTAL) ? m_ctr[a] : 0;
            for (int c = 0; c < NC; c++) begin
                old_pend = m_pend[c];
                rd  = req_fire[c] && !req_rw[c];
                wr  = req_fire[c] && req_rw[c];
                rsp = rsp_fire[c];
                if (rd && !rsp) begin
                    if (m_pend[c] == PMAX) m_ovf[c] = 1'b1; else m_pend[c]++;
                end else if (rsp && !rd) begin
                    if (m_pend[c] == 0) m_unf[c] = 1'b1; else m_pend[c]--;
                end
                if (enable) begin
                    m_ctr[NE+3*c]   = madd(m_ctr[NE+3*c], rd ? 1 : 0);
                    m_ctr[NE+3*c+1] = madd(m_ctr[NE+3*c+1], wr ? 1 : 0);
                    m_ctr[NE+3*c+2] = madd(m_ctr[NE+3*c+2], longint'(old_pend));
                end
            end
            if (enable)
                for (int i = 0; i < NE; i++) m_ctr[i] = madd(m_ctr[i], longint'(evt_inc[i*4 +: 4]));
            if (clear) begin
                foreach (m_ctr[i]) m_ctr[i] = 0;
                m_ovf = '0; m_unf = '0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable = 1'b1; clear = 1'b0; evt_inc = '0;
        req_fire = '0; req_rw = '0; rsp_fire = '0; rd_req = 1'b0; rd_addr = '0;
        n_enable = 1'b0; n_clear = 1'b0; n_evt_inc = '0; n_rd_req = 1'b0; n_rd_addr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL reset_rd_err got=%b exp=0", rd_err); end
        checks++; if (pend_ovf !== 2'b00 || pend_unf !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b/%b exp=00/00", pend_ovf, pend_unf); end
        rd_req = 1'b1; rd_addr = 4'd5;
        step();
        rd_req = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== '0) begin failures++; $display("FAIL reset_ctr5 got=%b/%0d exp=1/0", rd_valid, rd_data); end
    endtask

    task automatic test_event_count();
        do_reset();
        evt_inc[3*4 +: 4] = 4'd5;
        repeat (4) step();
        evt_inc = '0; rd_req = 1'b1; rd_addr = 4'd3;
        step();
        rd_req = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rd_data !== 44'd20)
            begin failures++; $display("FAIL event3_count got=v%b e%b d%0d exp=v1 e0 d20", rd_valid, rd_err, rd_data); end
        step();
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL idle_rd_valid got=%b exp=0", rd_valid); end
    endtask

    task automatic test_channel0_latency();
        do_reset();
        req_fire = 2'b01; req_rw = 2'b00;
        step();
        req_fire = '0;
        repeat (3) step();
        rsp_fire = 2'b01;
        step();
        rsp_fire = '0; rd_req = 1'b1;
        rd_addr = 4'd8;  step();
        checks++; if (rd_data !== 44'd1) begin failures++; $display("FAIL ch0_reads got=%0d exp=1", rd_data); end
        rd_addr = 4'd9;  step();
        checks++; if (rd_data !== 44'd0) begin failures++; $display("FAIL ch0_writes got=%0d exp=0", rd_data); end
        rd_addr = 4'd10; step();
        checks++; if (rd_data !== 44'd4) begin failures++; $display("FAIL ch0_latency got=%0d exp=4", rd_data); end
        rd_req = 1'b0;
        checks++; if (pend_unf[0] !== 1'b0) begin failures++; $display("FAIL ch0_unf got=%b exp=0", pend_unf[0]); end
    endtask

    task automatic test_channel1_underflow();
        do_reset();
        req_fire = 2'b10; req_rw = 2'b10; step();
        req_rw = 2'b00; step();
        req_fire = '0; rsp_fire = 2'b10; step();
        checks++; if (pend_unf !== 2'b00) begin failures++; $display("FAIL ch1_unf_early got=%b exp=00", pend_unf); end
        step();
        rsp_fire = '0;
        checks++; if (pend_unf !== 2'b10) begin failures++; $display("FAIL ch1_unf_set got=%b exp=10", pend_unf); end
        rd_req = 1'b1;
        rd_addr = 4'd11; step();
        checks++; if (rd_data !== 44'd1) begin failures++; $display("FAIL ch1_reads got=%0d exp=1", rd_data); end
        rd_addr = 4'd12; step();
        checks++; if (rd_data !== 44'd1) begin failures++; $display("FAIL ch1_writes got=%0d exp=1", rd_data); end
        rd_addr = 4'd13; step();
        checks++; if (rd_data !== 44'd1) begin failures++; $display("FAIL ch1_latency got=%0d exp=1", rd_data); end
        rd_req = 1'b0; clear = 1'b1; step();
        clear = 1'b0;
        checks++; if (pend_unf !== 2'b00) begin failures++; $display("FAIL ch1_unf_clear got=%b exp=00", pend_unf); end
        rsp_fire = 2'b10; step();
        rsp_fire = '0;
        checks++; if (pend_unf !== 2'b10) begin failures++; $display("FAIL ch1_tracker_held got=%b exp=10", pend_unf); end
    endtask

    task automatic test_enable_clear();
        do_reset();
        evt_inc[3:0] = 4'd3; repeat (2) step();
        enable = 1'b0; evt_inc[3:0] = 4'd7; repeat (10) step();
        rd_req = 1'b1; rd_addr = 4'd0; step();
        checks++; if (rd_data !== 44'd6) begin failures++; $display("FAIL enable_hold got=%0d exp=6", rd_data); end
        enable = 1'b1; clear = 1'b1; evt_inc[3:0] = 4'd2; step();
        checks++; if (rd_data !== 44'd6) begin failures++; $display("FAIL read_with_clear got=%0d exp=6", rd_data); end
        clear = 1'b0; evt_inc = '0; step();
        checks++; if (rd_data !== 44'd0) begin failures++; $display("FAIL clear_wins got=%0d exp=0", rd_data); end
        enable = 1'b0; evt_inc[3:0] = 4'd4; step();
        clear = 1'b1; step();
        clear = 1'b0; evt_inc = '0; enable = 1'b1; step();
        rd_req = 1'b0;
        checks++; if (rd_data !== 44'd0) begin failures++; $display("FAIL clear_disabled got=%0d exp=0", rd_data); end
    endtask

    task automatic test_narrow_wrap();
        logic [7:0] nexp;
`ifdef PERF_CTR_SATURATE_EN
        nexp = 8'd255;
`else
        nexp = 8'd44;
`endif
        do_reset();
        n_enable = 1'b1; n_evt_inc[7:4] = 4'd15;
        repeat (20) step();
        n_evt_inc = '0; n_rd_req = 1'b1; n_rd_addr = 4'd1; step();
        n_rd_req = 1'b0;
        checks++; if (n_rd_valid !== 1'b1 || n_rd_data !== nexp)
            begin failures++; $display("FAIL narrow_wrap got=v%b d%0d exp=v1 d%0d", n_rd_valid, n_rd_data, nexp); end
    endtask

    task automatic test_out_of_range_back_to_back();
        do_reset();
        repeat (5) begin evt_inc = $urandom; req_fire = 2'($urandom); req_rw = 2'($urandom); step(); end
        evt_inc = '0; req_fire = '0;
        rd_req = 1'b1;
        for (int a = 14; a < 16; a++) begin
            rd_addr = 4'(a); step();
            checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_data !== '0)
                begin failures++; $display("FAIL oor_addr%0d got=v%b e%b d%0d exp=v1 e1 d0", a, rd_valid, rd_err, rd_data); end
        end
        for (int k = 0; k < 6; k++) begin
            rd_addr = 4'($urandom_range(0, TOTAL-1)); evt_inc = $urandom; step();
            checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b0 || {20'b0, rd_data} !== exp_data)
                begin failures++; $display("FAIL b2b_read%0d got=v%b e%b d%0d exp=v1 e0 d%0d", k, rd_valid, rd_err, rd_data, exp_data); end
        end
        rd_req = 1'b0; evt_inc = '0; step();
        checks++; if (rd_valid !== 1'b0 || rd_err !== 1'b0) begin failures++; $display("FAIL b2b_idle got=v%b e%b exp=v0 e0", rd_valid, rd_err); end
    endtask

    task automatic test_pending_overflow();
        do_reset();
        req_fire = 2'b01; req_rw = 2'b00;
        repeat (255) step();
        checks++; if (pend_ovf !== 2'b00) begin failures++; $display("FAIL ovf_early got=%b exp=00", pend_ovf); end
        step();
        checks++; if (pend_ovf !== 2'b01) begin failures++; $display("FAIL ovf_set got=%b exp=01", pend_ovf); end
        req_fire = '0; rd_req = 1'b1; rd_addr = 4'd10; step();
        rd_req = 1'b0;
        checks++; if (rd_data !== 44'd32640) begin failures++; $display("FAIL ovf_latency got=%0d exp=32640", rd_data); end
        clear = 1'b1; step();
        clear = 1'b0;
        checks++; if (pend_ovf !== 2'b00) begin failures++; $display("FAIL ovf_clear got=%b exp=00", pend_ovf); end
        req_fire = 2'b01; step();
        req_fire = '0;
        checks++; if (pend_ovf !== 2'b01) begin failures++; $display("FAIL ovf_tracker_kept got=%b exp=01", pend_ovf); end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset    = ($urandom_range(0, 499) == 0);
            enable   = ($urandom_range(0, 7) != 0);
            clear    = ($urandom_range(0, 79) == 0);
            evt_inc  = $urandom;
            req_fire = 2'($urandom);
            req_rw   = 2'($urandom);
            rsp_fire = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
            rd_req   = $urandom_range(0, 1) == 1;
            rd_addr  = 4'($urandom);
            step();
            checks++; if (rd_valid !== exp_valid) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, rd_valid, exp_valid); end
            checks++; if (rd_err !== exp_err) begin failures++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", cyc, rd_err, exp_err); end
            if (exp_valid) begin
                checks++; if ({20'b0, rd_data} !== exp_data) begin failures++; $display("FAIL rand_data cyc=%0d addr=%0d got=%0d exp=%0d", cyc, rd_addr, rd_data, exp_data); end
            end
            checks++; if (pend_ovf !== m_ovf || pend_unf !== m_unf)
                begin failures++; $display("FAIL rand_flags cyc=%0d got=%b/%b exp=%b/%b", cyc, pend_ovf, pend_unf, m_ovf, m_unf); end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        n_zero = '0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_event_count();
        test_channel0_latency();
        test_channel1_underflow();
        test_enable_clear();
        test_narrow_wrap();
        test_out_of_range_back_to_back();
        test_pending_overflow();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
